// File: rtl/sonar_ping_sequencer.sv
// sonar_ping_sequencer
//
// Runs one sonar measurement ("ping") around the receive datapath:
//   CLEAR  - pulse mclear to reset the detector and timer
//   TX     - drive a differential transducer burst (tx_p / tx_n)
//   BLANK  - ignore the receiver while the transducer rings down
//   LISTEN - wait for the latched compare flag or the end of the window
//   DONE   - publish the result and pulse irq, then idle or re-arm
//
// Ports
//   wb_clk_i, wb_rst_i      clock, asynchronous active-low reset
//   start_i, abort_i        ping request (IDLE only) / synchronous abort
//   repeat_i                re-arm straight from DONE into CLEAR
//   ce_pcm, cmp             PCM-rate strobe and latched detector flag
//   half_period_i           clk cycles per transducer half-period (0 acts as 1)
//   burst_len_i             full transducer periods per ping
//   blank_len_i             blanking length in ce_pcm ticks
//   window_len_i            listen window in ce_pcm ticks
//   mclear                  one-cycle detector/timer clear
//   tx_p, tx_n              registered transducer drive, never both high
//   busy                    high whenever not IDLE
//   echo_valid/echo_timeout sticky result flags of the last ping
//   echo_time               ticks from BLANK entry to detection (all-ones on timeout)
//   irq                     one-cycle pulse while in DONE
module sonar_ping_sequencer #(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               repeat_i,
  input  logic               ce_pcm,
  input  logic               cmp,
  input  logic [CNT_W-1:0]   half_period_i,
  input  logic [BURST_W-1:0] burst_len_i,
  input  logic [CNT_W-1:0]   blank_len_i,
  input  logic [CNT_W-1:0]   window_len_i,
  output logic               mclear,
  output logic               tx_p,
  output logic               tx_n,
  output logic               busy,
  output logic               echo_valid,
  output logic               echo_timeout,
  output logic [CNT_W-1:0]   echo_time,
  output logic               irq
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_TX,
    S_BLANK,
    S_LISTEN,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [BURST_W:0] HALF_ONE = (BURST_W+1)'(1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   half_q, half_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [CNT_W-1:0]   blank_q, blank_d;
  logic [CNT_W-1:0]   window_q, window_d;
  logic [CNT_W-1:0]   hp_cnt_q, hp_cnt_d;
  logic [BURST_W:0]   half_cnt_q, half_cnt_d;
  logic [CNT_W-1:0]   echo_cnt_q, echo_cnt_d;
  logic [CNT_W-1:0]   win_cnt_q, win_cnt_d;
  logic               tx_p_q, tx_p_d;
  logic               tx_n_q, tx_n_d;
  logic               mclear_q, mclear_d;
  logic               busy_q, busy_d;
  logic               irq_q, irq_d;
  logic               echo_valid_q, echo_valid_d;
  logic               echo_timeout_q, echo_timeout_d;
  logic [CNT_W-1:0]   echo_time_q, echo_time_d;

  logic [CNT_W-1:0]   hp_eff;
  logic               hp_last;
  logic               half_last;
  logic [CNT_W-1:0]   echo_inc;
  logic [CNT_W-1:0]   win_inc;
  logic               arm;

  // Shared counter helpers. A zero half-period runs as one clk per half.
  // Both tick counters saturate so a very long window cannot wrap.
  always_comb begin
    hp_eff    = (half_q == '0) ? CNT_ONE : half_q;
    hp_last   = (hp_cnt_q == (hp_eff - CNT_ONE));
    half_last = (half_cnt_q == ({burst_q, 1'b0} - HALF_ONE));
    echo_inc  = (ce_pcm && (echo_cnt_q != CNT_MAX)) ? (echo_cnt_q + CNT_ONE) : echo_cnt_q;
    win_inc   = (ce_pcm && (win_cnt_q != CNT_MAX)) ? (win_cnt_q + CNT_ONE) : win_cnt_q;
  end

  // Next-state and datapath logic. Arming (from IDLE or a DONE re-arm)
  // snapshots the configuration and clears the result flags; abort is
  // applied last so it overrides everything, leaving the flags untouched.
  always_comb begin
    state_d        = state_q;
    half_d         = half_q;
    burst_d        = burst_q;
    blank_d        = blank_q;
    window_d       = window_q;
    hp_cnt_d       = hp_cnt_q;
    half_cnt_d     = half_cnt_q;
    echo_cnt_d     = echo_cnt_q;
    win_cnt_d      = win_cnt_q;
    tx_p_d         = 1'b0;
    tx_n_d         = 1'b0;
    echo_valid_d   = echo_valid_q;
    echo_timeout_d = echo_timeout_q;
    echo_time_d    = echo_time_q;
    arm            = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          arm = 1'b1;
        end
      end

      S_CLEAR: begin
        hp_cnt_d   = '0;
        half_cnt_d = '0;
        echo_cnt_d = '0;
        win_cnt_d  = '0;
        if (burst_q == '0) begin
          state_d = S_BLANK;
        end else begin
          state_d = S_TX;
          tx_p_d  = 1'b1;
        end
      end

      // The phase flops hold their value within a half-period and swap at
      // its end, so tx_p and tx_n are always complementary while bursting.
      S_TX: begin
        tx_p_d = tx_p_q;
        tx_n_d = tx_n_q;
        if (hp_last) begin
          hp_cnt_d = '0;
          if (half_last) begin
            state_d    = S_BLANK;
            tx_p_d     = 1'b0;
            tx_n_d     = 1'b0;
            echo_cnt_d = '0;
            win_cnt_d  = '0;
          end else begin
            half_cnt_d = half_cnt_q + HALF_ONE;
            tx_p_d     = tx_n_q;
            tx_n_d     = tx_p_q;
          end
        end else begin
          hp_cnt_d = hp_cnt_q + CNT_ONE;
        end
      end

      S_BLANK: begin
        echo_cnt_d = echo_inc;
        if ((blank_q == '0) || (ce_pcm && (echo_inc == blank_q))) begin
          state_d = S_LISTEN;
        end
      end

      // mclear_q is only high in the first LISTEN cycle, when cmp may still
      // carry a ring-down detection, so no decision is made in that cycle.
      S_LISTEN: begin
        echo_cnt_d = echo_inc;
        win_cnt_d  = win_inc;
        if (!mclear_q) begin
          if (cmp) begin
            state_d      = S_DONE;
            echo_valid_d = 1'b1;
            echo_time_d  = echo_inc;
          end else if (win_inc >= window_q) begin
            state_d        = S_DONE;
            echo_timeout_d = 1'b1;
            echo_time_d    = CNT_MAX;
          end
        end
      end

      S_DONE: begin
        if (repeat_i) begin
          arm = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (arm) begin
      state_d        = S_CLEAR;
      half_d         = half_period_i;
      burst_d        = burst_len_i;
      blank_d        = blank_len_i;
      window_d       = window_len_i;
      echo_valid_d   = 1'b0;
      echo_timeout_d = 1'b0;
      echo_time_d    = '0;
    end

    if (abort_i) begin
      state_d        = S_IDLE;
      half_d         = half_q;
      burst_d        = burst_q;
      blank_d        = blank_q;
      window_d       = window_q;
      tx_p_d         = 1'b0;
      tx_n_d         = 1'b0;
      echo_valid_d   = echo_valid_q;
      echo_timeout_d = echo_timeout_q;
      echo_time_d    = echo_time_q;
    end
  end

  // Registered status strobes, decoded from the state being entered.
  // mclear fires in CLEAR and again on the first LISTEN cycle.
  always_comb begin
    mclear_d = (state_d == S_CLEAR) || ((state_q == S_BLANK) && (state_d == S_LISTEN));
    busy_d   = (state_d != S_IDLE);
    irq_d    = (state_d == S_DONE);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q        <= S_IDLE;
      half_q         <= '0;
      burst_q        <= '0;
      blank_q        <= '0;
      window_q       <= '0;
      hp_cnt_q       <= '0;
      half_cnt_q     <= '0;
      echo_cnt_q     <= '0;
      win_cnt_q      <= '0;
      tx_p_q         <= 1'b0;
      tx_n_q         <= 1'b0;
      mclear_q       <= 1'b0;
      busy_q         <= 1'b0;
      irq_q          <= 1'b0;
      echo_valid_q   <= 1'b0;
      echo_timeout_q <= 1'b0;
      echo_time_q    <= '0;
    end else begin
      state_q        <= state_d;
      half_q         <= half_d;
      burst_q        <= burst_d;
      blank_q        <= blank_d;
      window_q       <= window_d;
      hp_cnt_q       <= hp_cnt_d;
      half_cnt_q     <= half_cnt_d;
      echo_cnt_q     <= echo_cnt_d;
      win_cnt_q      <= win_cnt_d;
      tx_p_q         <= tx_p_d;
      tx_n_q         <= tx_n_d;
      mclear_q       <= mclear_d;
      busy_q         <= busy_d;
      irq_q          <= irq_d;
      echo_valid_q   <= echo_valid_d;
      echo_timeout_q <= echo_timeout_d;
      echo_time_q    <= echo_time_d;
    end
  end

  assign mclear       = mclear_q;
  assign tx_p         = tx_p_q;
  assign tx_n         = tx_n_q;
  assign busy         = busy_q;
  assign irq          = irq_q;
  assign echo_valid   = echo_valid_q;
  assign echo_timeout = echo_timeout_q;
  assign echo_time    = echo_time_q;

endmodule

// File: tb/tb_sonar_ping_sequencer.sv
// tb_sonar_ping_sequencer
//
// Directed pings against sonar_ping_sequencer. Each ping pushes its
// hand-computed result into a queue; a monitor pops it whenever irq is
// seen and compares the result flags plus the mclear / tx activity it
// counted during that ping. A small latched detector model turns 'hit'
// pulses into cmp and is cleared by mclear, like the real receive chain.
module tb_sonar_ping_sequencer;

  localparam int CNT_W   = 16;
  localparam int BURST_W = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start_i = 1'b0;
  logic               abort_i = 1'b0;
  logic               repeat_i = 1'b0;
  logic               ce_pcm = 1'b0;
  logic               cmp;
  logic               hit = 1'b0;
  logic [CNT_W-1:0]   half_period_i = '0;
  logic [BURST_W-1:0] burst_len_i = '0;
  logic [CNT_W-1:0]   blank_len_i = '0;
  logic [CNT_W-1:0]   window_len_i = '0;
  logic               mclear, tx_p, tx_n, busy, echo_valid, echo_timeout, irq;
  logic [CNT_W-1:0]   echo_time;

  typedef struct packed {
    logic       valid;
    logic       timeout;
    logic [15:0] etime;
    logic [7:0] mclears;
    logic [7:0] txp;
    logic [7:0] txn;
  } exp_t;

  exp_t exp_q[$];

  int n_compared = 0;
  int n_mismatched = 0;
  int irq_seen = 0;

  // Monitor-private bookkeeping
  int   acc_mclear = 0;
  int   acc_txp = 0;
  int   acc_txn = 0;
  logic busy_prev = 1'b0;
  logic post_done_pending = 1'b0;
  logic exp_rearm = 1'b0;

  always #5 clk = ~clk;

  sonar_ping_sequencer #(.CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst_n),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .repeat_i      (repeat_i),
    .ce_pcm        (ce_pcm),
    .cmp           (cmp),
    .half_period_i (half_period_i),
    .burst_len_i   (burst_len_i),
    .blank_len_i   (blank_len_i),
    .window_len_i  (window_len_i),
    .mclear        (mclear),
    .tx_p          (tx_p),
    .tx_n          (tx_n),
    .busy          (busy),
    .echo_valid    (echo_valid),
    .echo_timeout  (echo_timeout),
    .echo_time     (echo_time),
    .irq           (irq)
  );

  // Latched threshold detector: set by a hit, cleared by mclear.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cmp <= 1'b0;
    else if (mclear) cmp <= 1'b0;
    else if (hit) cmp <= 1'b1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    n_compared++;
    if (actual !== required) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
    end
  endtask

  // Monitor: counts per-ping activity, scores each irq against the queue,
  // and checks what follows DONE (re-arm into CLEAR or drop to IDLE).
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_prev = 1'b0;
      post_done_pending = 1'b0;
    end else begin
      if (post_done_pending) begin
        post_done_pending = 1'b0;
        if (exp_rearm) begin
          checkOutput("rearm_busy", 32'(busy), 32'd1);
          checkOutput("rearm_mclear", 32'(mclear), 32'd1);
        end else begin
          checkOutput("after_done_busy", 32'(busy), 32'd0);
        end
      end
      if (tx_p && tx_n) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL tx_overlap: got tx_p=1 tx_n=1, expected never both high");
      end
      if (busy && !busy_prev) begin
        acc_mclear = 0;
        acc_txp = 0;
        acc_txn = 0;
      end
      acc_mclear += int'(mclear);
      acc_txp += int'(tx_p);
      acc_txn += int'(tx_n);
      if (irq) begin
        if (exp_q.size() == 0) begin
          n_compared++;
          n_mismatched++;
          $display("[TB] FAIL unexpected_irq: got irq=1, expected no irq");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("echo_valid", 32'(echo_valid), 32'(e.valid));
          checkOutput("echo_timeout", 32'(echo_timeout), 32'(e.timeout));
          checkOutput("echo_time", 32'(echo_time), 32'(e.etime));
          checkOutput("mclear_pulses", 32'(acc_mclear), 32'(e.mclears));
          checkOutput("tx_p_cycles", 32'(acc_txp), 32'(e.txp));
          checkOutput("tx_n_cycles", 32'(acc_txn), 32'(e.txn));
        end
        irq_seen++;
        post_done_pending = 1'b1;
        exp_rearm = repeat_i;
        acc_mclear = 0;
        acc_txp = 0;
        acc_txn = 0;
      end
      busy_prev = busy;
    end
  end

  // Load config and pulse start; the following cycle must be CLEAR.
  task automatic applyStimulus(input logic [15:0] hp, input logic [7:0] burst,
                               input logic [15:0] blank, input logic [15:0] win);
    @(negedge clk);
    half_period_i = hp;
    burst_len_i = burst;
    blank_len_i = blank;
    window_len_i = win;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    checkOutput("clear_mclear", 32'(mclear), 32'd1);
    checkOutput("clear_busy", 32'(busy), 32'd1);
    checkOutput("clear_tx", 32'({tx_p, tx_n}), 32'd0);
  endtask

  // ce_pcm strobes every 8 clks. A hit is placed either one cycle before
  // tick hit_tick (so cmp coincides with that tick) or just after it.
  task automatic runTicks(input int n_ticks, input int hit_tick, input bit same);
    for (int t = 1; t <= n_ticks; t++) begin
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        ce_pcm = (c == 7);
        hit = (hit_tick > 0) && (same ? (t == hit_tick && c == 6) : (t == hit_tick + 1 && c == 1));
      end
    end
    @(negedge clk);
    ce_pcm = 1'b0;
    hit = 1'b0;
  endtask

  task automatic runPing(input logic [15:0] hp, input logic [7:0] burst, input logic [15:0] blank,
                         input logic [15:0] win, input int pre_wait, input int n_ticks,
                         input int hit_tick, input bit same, input exp_t e);
    exp_q.push_back(e);
    applyStimulus(hp, burst, blank, win);
    repeat (pre_wait) @(negedge clk);
    runTicks(n_ticks, hit_tick, same);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #500000;
    n_compared++;
    n_mismatched++;
    $display("[TB] FAIL watchdog: got no finish by time limit, expected bench completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    int base;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
                32'({mclear, tx_p, tx_n, busy, irq, echo_valid, echo_timeout, echo_time}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] basic ping");
    runPing(16'd4, 8'd3, 16'd5, 16'd20, 26, 12, 9, 1'b0, '{1'b1, 1'b0, 16'd9, 8'd2, 8'd12, 8'd12});
    checkOutput("basic_held_valid", 32'(echo_valid), 32'd1);
    checkOutput("basic_held_time", 32'(echo_time), 32'd9);
    checkOutput("basic_idle_busy", 32'(busy), 32'd0);

    $display("[TB] timeout");
    runPing(16'd4, 8'd3, 16'd5, 16'd20, 26, 27, 0, 1'b0, '{1'b0, 1'b1, 16'hFFFF, 8'd2, 8'd12, 8'd12});

    $display("[TB] ring-down rejection");
    runPing(16'd4, 8'd3, 16'd5, 16'd20, 26, 27, 1, 1'b0, '{1'b0, 1'b1, 16'hFFFF, 8'd2, 8'd12, 8'd12});

    $display("[TB] cmp on final window tick");
    runPing(16'd4, 8'd3, 16'd5, 16'd20, 26, 27, 25, 1'b1, '{1'b1, 1'b0, 16'd25, 8'd2, 8'd12, 8'd12});

    $display("[TB] burst_len 0");
    runPing(16'd4, 8'd0, 16'd2, 16'd3, 2, 6, 0, 1'b0, '{1'b0, 1'b1, 16'hFFFF, 8'd2, 8'd0, 8'd0});

    $display("[TB] half_period 0");
    runPing(16'd0, 8'd2, 16'd1, 16'd2, 8, 4, 2, 1'b0, '{1'b1, 1'b0, 16'd2, 8'd2, 8'd2, 8'd2});

    $display("[TB] blank 0 / window 0");
    runPing(16'd1, 8'd1, 16'd0, 16'd0, 12, 0, 0, 1'b0, '{1'b0, 1'b1, 16'hFFFF, 8'd2, 8'd1, 8'd1});

    $display("[TB] abort mid-TX");
    applyStimulus(16'd4, 8'd3, 16'd5, 16'd20);
    repeat (4) @(negedge clk);
    checkOutput("abort_pre_tx", 32'(tx_p | tx_n), 32'd1);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    checkOutput("abort_tx", 32'({tx_p, tx_n}), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_flags", 32'({echo_valid, echo_timeout, echo_time}), 32'd0);
    repeat (40) @(negedge clk);
    start_i = 1'b1;
    abort_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    abort_i = 1'b0;
    checkOutput("start_with_abort_busy", 32'(busy), 32'd0);
    checkOutput("start_with_abort_mclear", 32'(mclear), 32'd0);

    $display("[TB] async reset mid-LISTEN");
    applyStimulus(16'd4, 8'd3, 16'd5, 16'd20);
    repeat (26) @(negedge clk);
    runTicks(7, 0, 1'b0);
    checkOutput("listen_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_outputs",
                32'({mclear, tx_p, tx_n, busy, irq, echo_valid, echo_timeout, echo_time}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] repeat mode");
    for (int i = 0; i < 3; i++) exp_q.push_back('{1'b0, 1'b1, 16'hFFFF, 8'd2, 8'd1, 8'd1});
    repeat_i = 1'b1;
    base = irq_seen;
    applyStimulus(16'd1, 8'd1, 16'd1, 16'd2);
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      ce_pcm = (cyc % 8 == 7);
      start_i = (cyc == 20);
      if ((irq_seen - base >= 2) && !irq) repeat_i = 1'b0;
      if ((irq_seen - base >= 3) && !busy) break;
    end
    ce_pcm = 1'b0;
    start_i = 1'b0;
    repeat_i = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("repeat_irq_count", 32'(irq_seen - base), 32'd3);
    checkOutput("repeat_final_timeout", 32'(echo_timeout), 32'd1);
    checkOutput("repeat_final_busy", 32'(busy), 32'd0);

    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/sonar_ping_sequencer.md
# sonar_ping_sequencer

Sequences one sonar measurement ("ping") around the receive datapath. Clears the detector and timer, drives a differential transducer burst, blanks the receiver during ring-down, then listens for the latched threshold-compare flag or a timeout. Reports echo time in PCM ticks and raises an interrupt. Sits between the Wishbone register file (configuration, start/abort) and the receive chain (consumes `ce_pcm` and `cmp`, drives `mclear`).

## Interface
- `CNT_W`, 16, width of half-period, blank, window and echo-time counters
- `BURST_W`, 8, width of burst-length field

Ports:
- `wb_clk_i`  in  1  system clock
- `wb_rst_i`  in  1  reset, asynchronous, active-low
- `start_i`  in  1  one-cycle start request; honoured only in IDLE
- `abort_i`  in  1  synchronous abort; highest priority after reset
- `repeat_i`  in  1  auto re-arm after DONE
- `ce_pcm`  in  1  PCM-rate strobe, one clk wide
- `cmp`  in  1  latched compare flag from detector
- `half_period_i`  in  CNT_W  clk cycles per transducer half-period (0 treated as 1)
- `burst_len_i`  in  BURST_W  full transducer periods per ping
- `blank_len_i`  in  CNT_W  blanking length in `ce_pcm` ticks
- `window_len_i`  in  CNT_W  listen window in `ce_pcm` ticks
- `mclear`  out  1  one-cycle detector/timer clear
- `tx_p`, `tx_n`  out  1 each  transducer drive, never both high
- `busy`  out  1  high in every state except IDLE
- `echo_valid`  out  1  sticky: last ping detected an echo
- `echo_timeout`  out  1  sticky: last ping timed out
- `echo_time`  out  CNT_W  ticks from BLANK entry to detection, held until next ping
- `irq`  out  1  one-cycle pulse in DONE

## Operation
- States: IDLE, CLEAR, TX, BLANK, LISTEN, DONE.
- IDLE: `start_i` → CLEAR. Latches all `*_i` config fields; mid-ping changes are ignored. Clears `echo_valid`, `echo_timeout` and `echo_time`.
- CLEAR: `mclear`=1 for exactly this cycle. Next state is TX, or BLANK if `burst_len`=0.
- TX: `tx_p`=1/`tx_n`=0 for `half_period` cycles, then swapped for `half_period` cycles, giving 2·`burst_len` half-periods. After the last half-period both outputs are 0 and the state becomes BLANK.
- BLANK: counts `ce_pcm` ticks in the echo-time counter. After `blank_len` ticks it moves to LISTEN; with `blank_len`=0 it moves immediately on the next cycle.
- BLANK→LISTEN transition: `mclear` pulses one cycle to discard ring-down detections. `cmp` is ignored in the first LISTEN cycle.
- LISTEN: the echo-time counter keeps counting ticks, saturating at all-ones; a separate window counter also counts ticks.
  - `cmp`=1 → DONE, `echo_valid`=1, `echo_time` = counter value.
  - Window counter reaching `window_len` → DONE, `echo_timeout`=1, `echo_time` = all-ones.
  - `cmp` and the final tick in the same cycle: echo wins.
  - `window_len`=0 → immediate timeout on the second LISTEN cycle.
- DONE: one cycle, `irq`=1. Next state is CLEAR if `repeat_i`=1, otherwise IDLE. Re-arm re-latches the config fields and clears the sticky flags, as in IDLE.
- Abort: `abort_i` in any state → IDLE next cycle.
  - `tx_p`/`tx_n` low, no `irq`, flags unchanged.
  - `start_i` together with `abort_i` in IDLE is ignored.
- Reset (async, any time, including mid-burst): state IDLE and all outputs 0.

## Timing
- `start_i` sampled at edge N → CLEAR during N+1 (`mclear`, `busy` high). First TX cycle is N+2.
- The transducer burst occupies exactly 2·`burst_len`·`half_period` clks.
- BLANK ends on the clk after the `blank_len`-th `ce_pcm` strobe. The LISTEN-entry `mclear` is the first LISTEN cycle.
- Detection latency: `cmp` high at edge M → DONE at M+1 → IDLE/CLEAR at M+2. `irq` is high in M+1 only.
- `echo_valid`, `echo_timeout` and `echo_time` update on entry to DONE and stay stable through IDLE.
- `tx_p`/`tx_n` are registered outputs; phase changes are glitch-free and never overlap.
- `busy` falls the cycle after DONE when `repeat_i`=0.

## Test plan
- Basic ping: `half_period`=4, `burst_len`=3, `blank_len`=5, `window_len`=20.
  - Stimulus: pulse `start_i`; strobe `ce_pcm` every 8 clks; raise `cmp` after the 9th tick.
  - Required: one `mclear` in CLEAR, 24 clks of alternating tx, a second `mclear` at LISTEN entry, `echo_valid`=1, `echo_time`=9, one `irq`.
- Timeout: same config, `cmp` held 0 → DONE after 25 ticks, `echo_timeout`=1, `echo_time`=0xFFFF, `echo_valid`=0.
- Ring-down rejection: `cmp`=1 throughout BLANK, then cleared by the LISTEN-entry `mclear` → no echo, `echo_timeout`=1.
- Edge lengths:
  - `burst_len`=0 → tx never toggles, CLEAR→BLANK directly.
  - `half_period`=0 → behaves as 1.
  - `cmp` rising on the final window tick → `echo_valid`=1, not timeout.
- Abort/reset: `abort_i` mid-TX → tx 0 next cycle, IDLE, no `irq`. Async `wb_rst_i` low mid-LISTEN → all outputs 0 immediately.
- Repeat: `repeat_i`=1 → DONE→CLEAR back-to-back, `busy` stays 1, flags cleared and re-evaluated each ping; `start_i` during `busy` is ignored.
